// File: rtl/phase_readout_pkg.sv
// Shared types and helpers for the phase readout block.
// Optional build macro: PHASE_DEGLITCH_EN (adds a 2-of-3 majority filter per tap).
package phase_readout_pkg;

  // Measurement sequencer states.
  typedef enum logic [1:0] {
    PR_IDLE   = 2'd0,
    PR_SETTLE = 2'd1,
    PR_COUNT  = 2'd2,
    PR_DONE   = 2'd3
  } pr_state_t;

  // Settle length: long enough to flush every stale sample from the tap pipeline.
  function automatic int settle_len(input int sync_stages);
`ifdef PHASE_DEGLITCH_EN
    return sync_stages + 2;
`else
    return sync_stages;
`endif
  endfunction

  // 2-of-3 majority vote.
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/phase_readout_if.sv
// Control/result bus between the register block (master) and phase_readout (slave).
interface phase_readout_if #(
  parameter int N     = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] window;
  logic             busy;
  logic             done;
  logic [N-1:0]     spins;

  modport master (output start, window, input busy, done, spins);
  modport slave  (input start, window, output busy, done, spins);
endinterface

// File: rtl/phase_readout_sync.sv
// Single-bit synchroniser chain for one asynchronous oscillator tap.
module phase_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic axi_rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] chain_reg;

  // Shift the raw tap through the flop chain; the oldest stage is the synchronised value.
  always_ff @(posedge clk) begin
    if (axi_rst) chain_reg <= '0;
    else         chain_reg <= {chain_reg[SYNC_STAGES-2:0], d};
  end

  assign q = chain_reg[SYNC_STAGES-1];
endmodule

// File: rtl/phase_readout.sv
// phase_readout: synchronises N oscillator taps, counts cycles each tap spends
// anti-phase to the reference tap (N-1) over a programmed window, and
// majority-decides one spin bit per oscillator.
// Optional build macro: PHASE_DEGLITCH_EN (2-of-3 majority filter after each synchroniser).
module phase_readout
  import phase_readout_pkg::*;
#(
  parameter int N           = 8,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            axi_rst,
  input  logic [N-1:0]    bot_row,
  phase_readout_if.slave  bus
);
  localparam int               L           = settle_len(SYNC_STAGES);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(L - 1);

  logic [N-1:0]     s;
  logic [N-1:0]     f;
  logic [N-1:0]     m;
  logic [CNT_W-1:0] cnt_reg  [N];
  logic [CNT_W-1:0] cnt_next [N];
  logic [N-1:0]     spin_now;
  logic [N-1:0]     spin_next;

  pr_state_t        state_reg;
  logic [CNT_W-1:0] win_q_reg;
  logic [CNT_W-1:0] tmr_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [N-1:0]     spins_reg;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_tap
      phase_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .axi_rst (axi_rst),
        .d       (bot_row[gi]),
        .q       (s[gi])
      );
`ifdef PHASE_DEGLITCH_EN
      logic [2:0] tap_reg;
      // Keep the last three synchronised samples so single-cycle glitches are outvoted.
      always_ff @(posedge clk) begin
        if (axi_rst) tap_reg <= '0;
        else         tap_reg <= {tap_reg[1:0], s[gi]};
      end
      assign f[gi] = maj3(tap_reg);
`else
      assign f[gi] = s[gi];
`endif
      // Reference bit compares with itself, so m[N-1] and spins[N-1] stay 0.
      assign m[gi]         = f[gi] ^ f[N-1];
      assign cnt_next[gi]  = cnt_reg[gi] + CNT_W'(m[gi]);
      assign spin_now[gi]  = cnt_reg[gi]  > (win_q_reg >> 1);
      assign spin_next[gi] = cnt_next[gi] > (win_q_reg >> 1);
    end
  endgenerate

  // Measurement sequencer: owns window capture, settle/window timer, counters and outputs.
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      state_reg <= PR_IDLE;
      win_q_reg <= '0;
      tmr_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      spins_reg <= '0;
      for (int i = 0; i < N; i++) cnt_reg[i] <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        PR_IDLE: begin
          if (bus.start) begin
            win_q_reg <= bus.window;
            tmr_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= PR_SETTLE;
            for (int i = 0; i < N; i++) cnt_reg[i] <= '0;
          end
        end
        PR_SETTLE: begin
          if (tmr_reg == SETTLE_LAST) begin
            tmr_reg <= '0;
            if (win_q_reg == '0) begin
              // Empty window: decide straight from the cleared counters.
              spins_reg <= spin_now;
              done_reg  <= 1'b1;
              state_reg <= PR_DONE;
            end else begin
              state_reg <= PR_COUNT;
            end
          end else begin
            tmr_reg <= tmr_reg + CNT_W'(1);
          end
        end
        PR_COUNT: begin
          for (int i = 0; i < N; i++) cnt_reg[i] <= cnt_next[i];
          if (tmr_reg == win_q_reg - CNT_W'(1)) begin
            // Decide on the post-increment counts so spins/done land in the DONE cycle.
            spins_reg <= spin_next;
            done_reg  <= 1'b1;
            state_reg <= PR_DONE;
          end else begin
            tmr_reg <= tmr_reg + CNT_W'(1);
          end
        end
        PR_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= PR_IDLE;
        end
        default: state_reg <= PR_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;
  assign bus.spins = spins_reg;
endmodule

// File: tb/tb_phase_readout.sv
// Directed testbench for phase_readout (N=8, CNT_W=16, SYNC_STAGES=2).
// Honours PHASE_DEGLITCH_EN for the settle length and glitch expectations.
module tb_phase_readout;
`ifdef PHASE_DEGLITCH_EN
  localparam int L         = 4;
  localparam int GLITCH_CNT = 0;
`else
  localparam int L         = 2;
  localparam int GLITCH_CNT = 1;
`endif

  logic       clk = 1'b0;
  logic       axi_rst;
  logic [7:0] bot_row;
  logic [7:0] mask [0:255];
  int         n_assert = 0;
  int         n_fail   = 0;
  int         lat;
  int         ndone;

  phase_readout_if #(.N(8), .CNT_W(16)) bus ();

  phase_readout #(.N(8), .CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .axi_rst (axi_rst),
    .bot_row (bot_row),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mask();
    for (int i = 0; i < 256; i++) mask[i] = 8'h00;
  endtask

  // Row value for sample k: slow reference square wave, XOR'd with the anti-phase mask.
  task automatic set_row(input int k);
    logic [31:0] kk;
    kk = k;
    bot_row = {8{kk[3]}} ^ mask[kk[7:0]];
  endtask

  // One measurement. Row value set for cycle k (k=1..win) is counted in COUNT sample k.
  task automatic run(input string name, input int win, input int exp_lat,
                     input int pulse_j, input bit pulse_on_done, output int lat_o);
    int j;
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.window = win[15:0];
    set_row(0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    j = 0;
    set_row(1);
    check({name, "_busy_rise"}, {31'd0, bus.busy}, 32'd1);
    lat_o = -1;
    while (j < 400 && lat_o < 0) begin
      if (bus.done === 1'b1) begin
        lat_o = j + 1;
      end else begin
        if (j == pulse_j) begin
          bus.start  = 1'b1;
          bus.window = 16'd50;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        j++;
        set_row(j + 1);
      end
    end
    check({name, "_latency"}, lat_o, exp_lat);
    if (lat_o >= 0) begin
      check({name, "_busy_in_done"}, {31'd0, bus.busy}, 32'd1);
      if (pulse_on_done) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check({name, "_done_single"}, {31'd0, bus.done}, 32'd0);
      check({name, "_busy_fall"}, {31'd0, bus.busy}, 32'd0);
      if (pulse_on_done) begin
        @(posedge clk); #1;
        check({name, "_no_restart"}, {31'd0, bus.busy}, 32'd0);
      end
    end
    $display("txn %s: window=%0d latency=%0d spins=%02h", name, win, lat_o, bus.spins);
  endtask

  initial begin
    axi_rst    = 1'b1;
    bus.start  = 1'b0;
    bus.window = '0;
    bot_row    = '0;
    clear_mask();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    check("rst_done",  {31'd0, bus.done}, 32'd0);
    check("rst_spins", {24'd0, bus.spins}, 32'd0);
    axi_rst = 1'b0;

    // 1: all taps in phase, start offered in the done cycle is ignored.
    clear_mask();
    run("inphase", 100, L + 101, -1, 1'b1, lat);
    check("inphase_spins", {24'd0, bus.spins}, 32'h00);

    // 2: osc 0 fully anti-phase for 64 samples.
    clear_mask();
    for (int k = 1; k <= 64; k++) mask[k] = 8'h01;
    run("osc0_anti", 64, L + 65, -1, 1'b0, lat);
    check("osc0_spins", {24'd0, bus.spins}, 32'h01);
    check("osc0_cnt0", {16'd0, dut.cnt_reg[0]}, 32'd64);
    check("osc0_cnt1", {16'd0, dut.cnt_reg[1]}, 32'd0);

    // 4: empty window; extra start while busy (with a new window) is ignored.
    clear_mask();
    run("win0", 0, L + 1, 0, 1'b0, lat);
    check("win0_spins", {24'd0, bus.spins}, 32'h00);
    ndone = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) ndone++;
    end
    check("win0_extra_done", ndone, 0);

    // 3a: exact tie (5 of 10) -> spin 0.
    clear_mask();
    for (int k = 1; k <= 5; k++) mask[k] = 8'h08;
    run("tie5", 10, L + 11, -1, 1'b0, lat);
    check("tie5_spins", {24'd0, bus.spins}, 32'h00);
    check("tie5_cnt3", {16'd0, dut.cnt_reg[3]}, 32'd5);

    // 3b: 6 of 10 -> spin 1.
    clear_mask();
    for (int k = 1; k <= 6; k++) mask[k] = 8'h08;
    run("maj6", 10, L + 11, -1, 1'b0, lat);
    check("maj6_spins", {24'd0, bus.spins}, 32'h08);

    // 5: reset mid-COUNT aborts without a done pulse and clears spins.
    clear_mask();
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.window = 16'd100;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
    axi_rst = 1'b1;
    @(posedge clk); #1;
    axi_rst = 1'b0;
    check("abort_busy",  {31'd0, bus.busy}, 32'd0);
    check("abort_done",  {31'd0, bus.done}, 32'd0);
    check("abort_spins", {24'd0, bus.spins}, 32'h00);
    ndone = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) ndone++;
    end
    check("abort_no_done", ndone, 0);
    $display("txn abort: done pulses after reset=%0d", ndone);

    // 6: single-cycle glitch on osc 2.
    clear_mask();
    mask[10] = 8'h04;
    run("glitch", 20, L + 21, -1, 1'b0, lat);
    check("glitch_cnt2",  {16'd0, dut.cnt_reg[2]}, GLITCH_CNT);
    check("glitch_spins", {24'd0, bus.spins}, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
